// File: rtl/imm_pkg.sv
// Shared definitions for the immediate packer: immsrc encodings, per-format
// immediate position masks in instr[31:7] layout (bit k is instr[k+7]) and
// the sign-range check used to decide whether an immediate is encodable.
package imm_pkg;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } immsrc_t;

   // instr[31:20]
   localparam logic [24:0] MASK_I = 25'h1FFE000;
   // instr[31:25] and instr[11:7]
   localparam logic [24:0] MASK_S = 25'h1FC001F;
   // same positions as S, scrambled differently
   localparam logic [24:0] MASK_B = 25'h1FC001F;
   // instr[31:12]
   localparam logic [24:0] MASK_J = 25'h1FFFFE0;

   // True when v[31:msb] are all equal, i.e. v is representable as a signed
   // value whose sign bit sits at position msb.
   function automatic logic fits_signed(input logic [31:0] v, input logic [4:0] msb);
      logic [31:0] s;
      s = 32'($signed(v) >>> msb);
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/imm_scatter.sv
// Combinational scatter of a 32-bit immediate into the instr[31:7] image for
// the selected format, together with the immediate position mask and the
// "not encodable" flag. The image is raw; forcing it to zero on error is left
// to the caller so the mask stays usable for merging fields.
module imm_scatter
   import imm_pkg::*;
(
   input  logic [31:0] imm,
   input  logic [1:0]  immsrc,
   output logic [24:0] image,
   output logic [24:0] mask,
   output logic        err
);

   // Place immediate bits per format and evaluate encodability.
   always_comb begin
      image = '0;
      mask  = '0;
      err   = 1'b0;
      case (immsrc_t'(immsrc))
         IMM_I: begin
            image[24:13] = imm[11:0];
            mask         = MASK_I;
            err          = !fits_signed(imm, 5'd11);
         end
         IMM_S: begin
            image[24:18] = imm[11:5];
            image[4:0]   = imm[4:0];
            mask         = MASK_S;
            err          = !fits_signed(imm, 5'd11);
         end
         IMM_B: begin
            image[24]    = imm[12];
            image[23:18] = imm[10:5];
            image[4:1]   = imm[4:1];
            image[0]     = imm[11];
            mask         = MASK_B;
            err          = imm[0] || !fits_signed(imm, 5'd12);
         end
         default: begin
            image[24]    = imm[20];
            image[23:14] = imm[10:1];
            image[13]    = imm[11];
            image[12:5]  = imm[19:12];
            mask         = MASK_J;
            err          = imm[0] || !fits_signed(imm, 5'd20);
         end
      endcase
   end

endmodule

// File: rtl/imm_pack.sv
// Two-stage pipelined immediate packer with valid/ready handshakes.
// S1 holds the accepted request; the scatter/mask/error logic works on it.
// S2 is the output register holding the merged instruction.
// Optional feature: define IMM_PACK_ERRCNT_EN to get a saturating counter of
// error beats handed off at the output; otherwise err_count is tied to 0.
module imm_pack
   import imm_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      imm,
   input  logic [1:0]       immsrc,
   input  logic [24:0]      fields,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [24:0]      instr,
   output logic             out_err,
   output logic [CNT_W-1:0] err_count
);

   logic        s1_valid;
   logic        s2_valid;
   logic        s2_load;
   logic        in_fire;
   logic [31:0] s1_imm;
   logic [1:0]  s1_immsrc;
   logic [24:0] s1_fields;
   logic [24:0] image;
   logic [24:0] mask;
   logic        s1_err;
   logic [24:0] merged;

   imm_scatter u_scatter (
      .imm    (s1_imm),
      .immsrc (s1_immsrc),
      .image  (image),
      .mask   (mask),
      .err    (s1_err)
   );

   // Fields fill every non-immediate position; immediate positions get the
   // scattered value, or zero when the immediate is not encodable.
   assign merged = (s1_fields & ~mask) | (s1_err ? 25'd0 : image);

   assign s2_load   = !s2_valid || out_ready;
   assign in_ready  = !s1_valid || s2_load;
   assign in_fire   = in_valid && in_ready;
   assign out_valid = s2_valid;

   // ---- S1: request register ----
   // S1 occupancy: fill on accept, drain when S2 takes the beat.
   always_ff @(posedge clk) begin
      if (reset)
         s1_valid <= 1'b0;
      else if (in_fire)
         s1_valid <= 1'b1;
      else if (s2_load)
         s1_valid <= 1'b0;
   end

   // S1 payload: sampled only on the input handshake.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         s1_imm    <= imm;
         s1_immsrc <= immsrc;
         s1_fields <= fields;
      end
   end

   // ---- S2: output register ----
   // S2 advances whenever it is empty or being consumed; holds otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid <= 1'b0;
         instr    <= '0;
         out_err  <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            instr   <= merged;
            out_err <= s1_err;
         end
      end
   end

`ifdef IMM_PACK_ERRCNT_EN
   logic [CNT_W-1:0] err_cnt;

   // Count error beats at the output handshake, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (reset)
         err_cnt <= '0;
      else if (s2_valid && out_ready && out_err && (err_cnt != '1))
         err_cnt <= err_cnt + CNT_W'(1);
   end

   assign err_count = err_cnt;
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_imm_pack.sv
// Self-checking bench for imm_pack: directed literal cases, backpressure,
// reset-in-flight and randomized traffic against a behavioural model.
// Honours IMM_PACK_ERRCNT_EN the same way as the design.
module tb_imm_pack;

   localparam int CNT_W = 2;
   localparam logic [1:0] T_I = 2'b00, T_S = 2'b01, T_B = 2'b10, T_J = 2'b11;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic [31:0]      imm = '0;
   logic [1:0]       immsrc = '0;
   logic [24:0]      fields = '0;
   logic             in_ready;
   logic             out_valid;
   logic             out_err;
   logic [24:0]      instr;
   logic [CNT_W-1:0] err_count;

   imm_pack #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .imm       (imm),
      .immsrc    (immsrc),
      .fields    (fields),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .instr     (instr),
      .out_err   (out_err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference packer on the full 32-bit instruction word.
   function automatic void ref_pack(input logic [31:0] v, input logic [1:0] src,
                                    input logic [24:0] f, output logic [31:0] word,
                                    output logic err);
      logic [31:0] img, msk;
      logic        ok;
      int          sv;
      sv = $signed(v);
      case (src)
         T_I: begin
            img = {v[11:0], 20'b0};
            msk = 32'hFFF0_0000;
            ok  = (sv >= -2048) && (sv <= 2047);
         end
         T_S: begin
            img = {v[11:5], 13'b0, v[4:0], 7'b0};
            msk = 32'hFE00_0F80;
            ok  = (sv >= -2048) && (sv <= 2047);
         end
         T_B: begin
            img = {v[12], v[10:5], 13'b0, v[4:1], v[11], 7'b0};
            msk = 32'hFE00_0F80;
            ok  = !v[0] && (sv >= -4096) && (sv <= 4095);
         end
         default: begin
            img = {v[20], v[10:1], v[11], v[19:12], 12'b0};
            msk = 32'hFFFF_F000;
            ok  = !v[0] && (sv >= -(1 << 20)) && (sv <= (1 << 20) - 1);
         end
      endcase
      err  = !ok;
      word = ({f, 7'b0} & ~msk) | (ok ? img : 32'd0);
   endfunction

   // Decode-side extender, used for the round-trip property.
   function automatic logic [31:0] extend(input logic [31:0] i, input logic [1:0] src);
      case (src)
         T_I:     return {{20{i[31]}}, i[31:20]};
         T_S:     return {{20{i[31]}}, i[31:25], i[11:7]};
         T_B:     return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      endcase
   endfunction

   typedef struct {
      logic [31:0] word;
      logic        err;
      logic [31:0] imm;
      logic [1:0]  src;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_err = 0;
   bit   post_rst = 1'b0;

   // Compare process: every cycle, check handshake, ordering and contents.
   always @(negedge clk) begin
      logic [31:0] w;
      logic        e;
      logic        exp_ready;
      logic        exp_vld;
      int          exp_cnt;
      exp_t        it;
      cyc++;
      if (reset) begin
         q.delete();
         n_err    = 0;
         post_rst = 1'b1;
      end else begin
         if (post_rst) begin
            check("rst_instr", {7'b0, instr}, 32'd0);
            check("rst_out_err", {31'b0, out_err}, 32'd0);
            post_rst = 1'b0;
         end
         exp_ready = (q.size() < 2) || out_ready;
         check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
         exp_vld = (q.size() > 0) && (cyc - q[0].acc >= 2);
         check("out_valid", {31'b0, out_valid}, {31'b0, exp_vld});
`ifdef IMM_PACK_ERRCNT_EN
         exp_cnt = (n_err > 3) ? 3 : n_err;
`else
         exp_cnt = 0;
`endif
         check("err_count", 32'(err_count), 32'(exp_cnt));
         if (out_valid && q.size() > 0) begin
            check("instr", {instr, 7'b0}, q[0].word);
            check("out_err", {31'b0, out_err}, {31'b0, q[0].err});
            if (!q[0].err)
               check("round_trip", extend({instr, 7'b0}, q[0].src), q[0].imm);
            if (out_ready) begin
               if (q[0].err) n_err++;
               void'(q.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            ref_pack(imm, immsrc, fields, w, e);
            it.word = w; it.err = e; it.imm = imm; it.src = immsrc; it.acc = cyc;
            q.push_back(it);
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Present one beat (caller at posedge+1) and hold it until accepted.
   task automatic push(input logic [31:0] v, input logic [1:0] src, input logic [24:0] f);
      int n;
      in_valid = 1'b1;
      imm      = v;
      immsrc   = src;
      fields   = f;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 50);
      if (!in_ready) check("push_timeout", 32'd0, 32'd1);
      sync();
      in_valid = 1'b0;
   endtask

   // Single beat into an empty pipeline: check latency and literal result.
   task automatic send_expect(input string name, input logic [31:0] v, input logic [1:0] src,
                              input logic [24:0] f, input logic [31:0] word, input logic err);
      int n;
      sync();
      push(v, src, f);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 10);
      check({name, "_latency"}, 32'(n), 32'd2);
      check({name, "_word"}, {instr, 7'b0}, word);
      check({name, "_err"}, {31'b0, out_err}, {31'b0, err});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      logic [31:0] v;
      repeat (3) @(posedge clk);
      #1;
      reset     = 1'b0;
      out_ready = 1'b1;

      send_expect("i_neg", 32'hFFFF_F800, T_I, 25'd0, 32'h8000_0000, 1'b0);
      send_expect("s_7f",  32'h0000_007F, T_S, 25'd0, 32'h0600_0F80, 1'b0);
      send_expect("b_m2",  32'hFFFF_FFFE, T_B, 25'd0, 32'hFE00_0F80, 1'b0);
      send_expect("j_800", 32'h0000_0800, T_J, 25'd5, 32'h0010_0280, 1'b0);
      send_expect("j_odd", 32'h0000_0001, T_J, 25'd0, 32'h0000_0000, 1'b1);
      sync();
`ifdef IMM_PACK_ERRCNT_EN
      check("errcnt_one", 32'(err_count), 32'd1);
`else
      check("errcnt_one", 32'(err_count), 32'd0);
`endif
      send_expect("i_oor", 32'h0000_0800, T_I, 25'h1FF_FFFF, 32'h000F_FF80, 1'b1);
      sync();
      for (int i = 0; i < 10; i++) push(32'h0000_0001, T_B, 25'd0);
      repeat (4) sync();
`ifdef IMM_PACK_ERRCNT_EN
      check("errcnt_sat", 32'(err_count), 32'd3);
`else
      check("errcnt_sat", 32'(err_count), 32'd0);
`endif

      // Backpressure: two beats held, third waits until out_ready rises.
      out_ready = 1'b0;
      push(32'd1, T_I, 25'd0);
      push(32'd2, T_I, 25'd0);
      in_valid = 1'b1;
      imm      = 32'd3;
      immsrc   = T_I;
      fields   = 25'd0;
      @(negedge clk);
      check("bp_full_ready", {31'b0, in_ready}, 32'd0);
      repeat (2) @(negedge clk);
      check("bp_hold_word", {instr, 7'b0}, 32'h0010_0000);
      sync();
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_shift_ready", {31'b0, in_ready}, 32'd1);
      check("bp_out1", {31'b0, out_valid}, 32'd1);
      sync();
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_out2", {instr, 7'b0}, 32'h0020_0000);
      @(negedge clk);
      check("bp_out3", {instr, 7'b0}, 32'h0030_0000);
      repeat (3) sync();

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         immsrc    = 2'($urandom);
         fields    = 25'($urandom);
         if ($urandom % 5 == 0) begin
            imm = $urandom;
         end else begin
            w = $urandom_range(8, 23);
            v = $urandom;
            imm = 32'($signed(v << (32 - w)) >>> (32 - w));
            if ($urandom % 2 == 0) imm[0] = 1'b0;
         end
         sync();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (5) sync();

      // Reset with two beats in flight: nothing may emerge afterwards.
      out_ready = 1'b0;
      push(32'd5, T_S, 25'd0);
      push(32'h0000_0FFF, T_J, 25'd0);
      reset = 1'b1;
      sync();
      reset     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("rst_ready", {31'b0, in_ready}, 32'd1);
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_errcnt", 32'(err_count), 32'd0);
      repeat (4) sync();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/imm_pack.md
# imm_pack

Pipelined immediate packer: the inverse of the decode-side immediate extender. It takes a 32-bit signed immediate and an `immsrc` type, and scatters the immediate bits into the instruction positions `instr[31:7]` for I/S/B/J formats. It merges them with caller-supplied non-immediate fields and flags immediates that cannot be encoded. It sits in the instruction-generation path (self-test ROM builder / patch unit) and feeds the same `instr[31:7]` layout the extender consumes.

## Interface
- `CNT_W`, default 16: width of the saturating error counter.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `imm` in 32: signed immediate to encode.
- `immsrc` in 2: 00 I, 01 S, 10 B, 11 J (same encoding as the extender).
- `fields` in 25: non-immediate bits in `instr[31:7]` layout; bits in immediate positions are ignored.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.
- `instr` out 25: packed `instr[31:7]`.
- `out_err` out 1: immediate not encodable for `immsrc`.
- `err_count` out CNT_W: see Configuration.

## Operation
- Immediate bit positions:
  - I: `instr[31:20]=imm[11:0]`.
  - S: `instr[31:25]=imm[11:5]`, `instr[11:7]=imm[4:0]`.
  - B: `instr[31]=imm[12]`, `instr[30:25]=imm[10:5]`, `instr[11:8]=imm[4:1]`, `instr[7]=imm[11]`.
  - J: `instr[31]=imm[20]`, `instr[30:21]=imm[10:1]`, `instr[20]=imm[11]`, `instr[19:12]=imm[19:12]`.
- Non-immediate positions take `fields`. Immediate positions never take `fields`.
- Encodability:
  - I/S: `imm[31:11]` all equal.
  - B: `imm[0]==0` and `imm[31:12]` all equal.
  - J: `imm[0]==0` and `imm[31:20]` all equal.
- On error: `out_err=1`, all immediate positions forced to 0, non-immediate positions still taken from `fields`.
- Round-trip property: for `out_err==0`, the extender applied to `instr` with the same `immsrc` returns `imm`.
- Two-stage pipeline:
  - S1 registers the request and computes mask and error.
  - S2 is the output register holding the merged instruction.
- Each stage has its own valid bit. Stage N loads when it is empty or stage N+1 accepts in the same cycle.
- `in_ready = !s1_valid || s2_load`, where `s2_load = !s2_valid || out_ready`.
- Outputs stay stable while `out_valid && !out_ready`. Order is preserved and no beat is dropped or duplicated.

## Timing
- Latency: an accepted request appears on `out_valid` 2 cycles later when not stalled.
- Throughput: 1 per cycle with `out_ready` held high.
- Full: both stages valid and `out_ready=0` → `in_ready=0` combinationally in the same cycle.
- Simultaneous accept and consume while full: `out_ready=1` raises `in_ready` in the same cycle. The pipeline shifts with no bubble.
- Reset:
  - Clears `s1_valid`, `s2_valid`, `instr`, `out_err` and `err_count` to 0.
  - `in_ready` reads 1 from the first cycle after reset.
  - Reset mid-operation discards in-flight beats and produces no output for them.
- `in_valid` may drop without acceptance. Data is only sampled on the handshake.

## Configuration
- `IMM_PACK_ERRCNT_EN` defined:
  - `err_count` increments by 1 on every output handshake with `out_err=1`.
  - It saturates at `2^CNT_W-1` and is cleared only by reset.
- Not defined: `err_count` is tied to 0 and no counter flops exist. All other behaviour is identical.

## Structure
- Shared package `imm_pkg`:
  - `immsrc` encodings `IMM_I/IMM_S/IMM_B/IMM_J`.
  - Per-type 25-bit immediate position masks.
  - Common function for the sign-range check, shared with the extender bench.
- Sub-module `imm_scatter`: combinational scatter, `imm`/`immsrc` → 25-bit immediate image plus mask. `imm_pack` holds only the pipeline, handshake and counter.

## Test plan
- I, `imm=0xFFFFF800`, `fields=0` → `{instr,7'b0}=0x80000000`, `out_err=0`, 2 cycles after accept.
- S, `imm=0x0000007F`, `fields=0` → `0x06000F80`. B, `imm=0xFFFFFFFE` → `0xFE000F80`.
- J, `imm=0x00000800`, `fields` rd=5 → `0x00100280`. J, `imm=0x00000001` → `out_err=1`, immediate bits 0, `err_count=1` with the macro and 0 without.
- I, `imm=0x00000800` (out of range) → `out_err=1`. Then 10 error beats with `CNT_W=2` → `err_count` saturates at 3.
- Backpressure:
  - Stimulus: `out_ready=0`, push 3 beats back-to-back.
  - Response: `in_ready` drops after 2 are held, with beat 3 waiting. Raise `out_ready` → outputs emerge in order with no gap.
- Assert `reset` with 2 beats in flight → no `out_valid` afterwards, `in_ready=1`, `err_count=0`.
